// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Streams instruction words from a boot source into the instruction RAM,
// starting at a programmable base address. The CPU is held in reset for the
// whole load and released only when the load completes cleanly.
//
// Optional feature (compile-time macro):
//   PROGRAM_LOADER_VERIFY_EN - after the last write, read the loaded region
//                              back, sum it and compare the sum with the
//                              running checksum before releasing the CPU.
//
// Ports:
//   clk             system clock (all state changes on its rising edge)
//   reset           synchronous, active-high reset
//   start           one-cycle pulse that begins a load (ignored while busy)
//   base_addr       first RAM address, sampled on start
//   src_valid       source word valid
//   src_data        source instruction word
//   src_last        marks the final word, qualified by src_valid
//   src_ready       loader accepts a word this cycle
//   mem_enable      RAM enable strobe
//   mem_read_write  0 = write, 1 = read
//   mem_address     RAM address
//   mem_data_in     RAM write data
//   mem_data_out    RAM read data, valid the cycle after a read strobe
//   cpu_reset       holds the CPU in reset
//   busy            load (or verify) in progress
//   done            sticky load success
//   error           sticky load failure
//   word_count      words written in the current/last load
//   checksum        sum of accepted words, modulo 2^DATA_W
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_last,
    output logic              src_ready,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
);

    // Word count at which a load without src_last is declared an overflow.
    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DONE   = 3'd2,
`ifdef PROGRAM_LOADER_VERIFY_EN
        ST_ERROR  = 3'd3,
        ST_VERIFY = 3'd4
`else
        ST_ERROR  = 3'd3
`endif
    } state_t;

    // RAM address of word <offset> of the load; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] f_wrap_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W:0]   offset
    );
        return base + offset[ADDR_W-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_word_count;
    logic [DATA_W-1:0]   r_checksum;

    logic                r_src_ready;
    logic                r_mem_enable;
    logic                r_mem_read_write;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_data_in;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    // Next values of the registered outputs
    logic                w_src_ready_nxt;
    logic                w_mem_enable_nxt;
    logic                w_mem_read_write_nxt;
    logic [ADDR_W-1:0]   w_mem_address_nxt;
    logic [DATA_W-1:0]   w_mem_data_in_nxt;
    logic                w_cpu_reset_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_error_nxt;

    // Control decodes
    logic                w_start_ok;
    logic                w_hs;
    logic [ADDR_W:0]     w_wc_inc;
    logic                w_overflow;

`ifdef PROGRAM_LOADER_VERIFY_EN
    logic [ADDR_W:0]     r_vidx;     // read strobes issued so far
    logic                r_rd_pend;  // read data arrives on mem_data_out this cycle
    logic [DATA_W-1:0]   r_rsum;     // readback sum
    logic                w_rd_issue;
    logic                w_cmp;
`else
    logic                w_unused_rdata;
    assign w_unused_rdata = ^mem_data_out;
`endif

    // start is honoured only from the resting states, so a pulse mid-load is ignored.
    assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERROR));
    assign w_hs       = (r_state == ST_LOAD) & src_valid & r_src_ready;
    assign w_wc_inc   = r_word_count + (ADDR_W+1)'(1);
    // Reaching DEPTH on the last word is legal; only a non-last word there overflows.
    assign w_overflow = w_hs & ~src_last & (w_wc_inc == L_DEPTH);

`ifdef PROGRAM_LOADER_VERIFY_EN
    assign w_rd_issue = (r_state == ST_VERIFY) & (r_vidx != r_word_count);
    // All reads issued, the last strobe gone and its data already summed.
    assign w_cmp      = (r_state == ST_VERIFY) & (r_vidx == r_word_count)
                        & ~r_mem_enable & ~r_rd_pend;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LOAD: begin
                if (w_hs && src_last) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
                    w_state_nxt = ST_VERIFY;
`else
                    w_state_nxt = ST_DONE;
`endif
                end else if (w_overflow) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
`ifdef PROGRAM_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (w_cmp) begin
                    if (r_rsum == r_checksum) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ERROR;
                    end
                end else begin
                    w_state_nxt = ST_VERIFY;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered status and memory port
    always_comb begin
        w_src_ready_nxt      = (w_state_nxt == ST_LOAD);
`ifdef PROGRAM_LOADER_VERIFY_EN
        w_busy_nxt           = (w_state_nxt == ST_LOAD) | (w_state_nxt == ST_VERIFY);
`else
        w_busy_nxt           = (w_state_nxt == ST_LOAD);
`endif
        w_cpu_reset_nxt      = (w_state_nxt != ST_DONE);
        w_done_nxt           = (w_state_nxt == ST_DONE);
        w_error_nxt          = (w_state_nxt == ST_ERROR);
        w_mem_enable_nxt     = 1'b0;
        w_mem_read_write_nxt = 1'b1;
        w_mem_address_nxt    = r_mem_address;
        w_mem_data_in_nxt    = r_mem_data_in;
        // Every accepted word becomes a write strobe on the following cycle,
        // including the final one while the FSM is already leaving LOAD.
        if (w_hs) begin
            w_mem_enable_nxt     = 1'b1;
            w_mem_read_write_nxt = 1'b0;
            w_mem_address_nxt    = f_wrap_addr(r_base, r_word_count);
            w_mem_data_in_nxt    = src_data;
        end
`ifdef PROGRAM_LOADER_VERIFY_EN
        else if (w_rd_issue) begin
            w_mem_enable_nxt     = 1'b1;
            w_mem_read_write_nxt = 1'b1;
            w_mem_address_nxt    = f_wrap_addr(r_base, r_vidx);
        end
`endif
        else begin
            w_mem_enable_nxt     = 1'b0;
            w_mem_read_write_nxt = 1'b1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ready      <= 1'b0;
            r_mem_enable     <= 1'b0;
            r_mem_read_write <= 1'b1;
            r_mem_address    <= '0;
            r_mem_data_in    <= '0;
            r_cpu_reset      <= 1'b1;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
        end else begin
            r_src_ready      <= w_src_ready_nxt;
            r_mem_enable     <= w_mem_enable_nxt;
            r_mem_read_write <= w_mem_read_write_nxt;
            r_mem_address    <= w_mem_address_nxt;
            r_mem_data_in    <= w_mem_data_in_nxt;
            r_cpu_reset      <= w_cpu_reset_nxt;
            r_busy           <= w_busy_nxt;
            r_done           <= w_done_nxt;
            r_error          <= w_error_nxt;
        end
    end

    // Base address latch, word counter and running checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base       <= '0;
            r_word_count <= '0;
            r_checksum   <= '0;
        end else if (w_start_ok) begin
            r_base       <= base_addr;
            r_word_count <= '0;
            r_checksum   <= '0;
        end else if (w_hs) begin
            r_word_count <= w_wc_inc;
            r_checksum   <= r_checksum + src_data;
        end else begin
            r_word_count <= r_word_count;
            r_checksum   <= r_checksum;
        end
    end

`ifdef PROGRAM_LOADER_VERIFY_EN
    // Readback sequencing: strobe index, read-data pipeline flag and readback sum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vidx    <= '0;
            r_rd_pend <= 1'b0;
            r_rsum    <= '0;
        end else if (w_start_ok) begin
            r_vidx    <= '0;
            r_rd_pend <= 1'b0;
            r_rsum    <= '0;
        end else begin
            if (w_rd_issue) begin
                r_vidx <= r_vidx + (ADDR_W+1)'(1);
            end else begin
                r_vidx <= r_vidx;
            end
            // A read strobe on the bus now means its data is on mem_data_out next cycle.
            r_rd_pend <= r_mem_enable & r_mem_read_write;
            if (r_rd_pend) begin
                r_rsum <= r_rsum + mem_data_out;
            end else begin
                r_rsum <= r_rsum;
            end
        end
    end
`endif

    assign src_ready      = r_src_ready;
    assign mem_enable     = r_mem_enable;
    assign mem_read_write = r_mem_read_write;
    assign mem_address    = r_mem_address;
    assign mem_data_in    = r_mem_data_in;
    assign cpu_reset      = r_cpu_reset;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign word_count     = r_word_count;
    assign checksum       = r_checksum;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Randomised self-checking bench for program_loader. A behavioural RAM sits on
// the memory port, a monitor logs every write/read strobe, and each load is
// checked against expectations computed from the word list: accepted count,
// write addresses (base+i wrapping), data, checksum and final status flags.
// Uses DEPTH=8 so the overflow and exact-DEPTH boundaries are cheap to reach.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_last;
    logic          src_ready;
    logic          mem_enable;
    logic          mem_read_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;
    logic [DW-1:0] checksum;

    always #5 clk = ~clk;

    program_loader #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_last       (src_last),
        .src_ready      (src_ready),
        .mem_enable     (mem_enable),
        .mem_read_write (mem_read_write),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .cpu_reset      (cpu_reset),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .word_count     (word_count),
        .checksum       (checksum)
    );

    // Behavioural synchronous RAM; fault_en corrupts bit 0 of address 3 on readback.
    logic [DW-1:0] ram [0:65535];
    logic          fault_en;

    always @(posedge clk) begin
        if (mem_enable) begin
            if (!mem_read_write) ram[mem_address] <= mem_data_in;
            else mem_data_out <= ram[mem_address] ^ {31'd0, (fault_en && mem_address == 16'd3)};
        end
    end

    // Strobe monitor
    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    logic [31:0]   cyc = 32'd0;

    always @(negedge clk) begin
        wr_t e;
        cyc = cyc + 32'd1;
        if (mem_enable) begin
            if (!mem_read_write) begin
                e.cyc = cyc; e.addr = mem_address; e.data = mem_data_in;
                wq.push_back(e);
            end else begin
                rq.push_back(mem_address);
            end
        end
    end

    logic [DW-1:0] words[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then offer words[0..n-1]; gap_mode 0 = every cycle,
    // 1 = every other cycle, 2 = random. Stops early once stop_at words are accepted.
    task automatic drive_words(input logic [AW-1:0] base, input int n, input bit has_last,
                               input int gap_mode, input int stop_at, output int acc);
        int  i;
        int  guard;
        bit  v;
        bit  rdy;
        @(negedge clk);
        start = 1'b1; base_addr = base;
        @(negedge clk);
        start = 1'b0; base_addr = AW'($urandom);
        i = 0; guard = 0;
        while (i < n && guard < 4*n + 20 && !(stop_at > 0 && i == stop_at)) begin
            rdy = src_ready;
            case (gap_mode)
                0: v = 1'b1;
                1: v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            src_valid = v;
            src_data  = words[i];
            src_last  = has_last && (i == n - 1);
            if (v && rdy) i++;
            guard++;
            @(negedge clk);
        end
        src_valid = 1'b0; src_last = 1'b0; src_data = '0;
        acc = i;
    endtask

    // Run one load and compare everything against the word-list model.
    task automatic do_load(input string tag, input logic [AW-1:0] base, input int n,
                           input bit has_last, input int gap_mode);
        int            acc;
        int            acc_exp;
        int            wb;
        int            rb;
        int            k;
        int            exp_busy;
        int            exp_reads;
        bit            complete;
        bit            exp_err;
        logic [DW-1:0] sum;
        logic [AW-1:0] ea;
        wb = wq.size(); rb = rq.size();
        complete = has_last && (n <= DEPTH);
        acc_exp  = (n < DEPTH) ? n : DEPTH;
        sum = '0;
        for (int j = 0; j < acc_exp; j++) sum = sum + words[j];
        exp_err = !complete;
`ifdef PROGRAM_LOADER_VERIFY_EN
        if (complete && fault_en)
            for (int j = 0; j < acc_exp; j++)
                if (AW'(base + AW'(j)) == 16'd3) exp_err = 1'b1;
        // final write cycle followed by word_count+2 verify cycles
        exp_busy  = complete ? n + 3 : 0;
        exp_reads = complete ? acc_exp : 0;
`else
        exp_busy  = 0;
        exp_reads = 0;
`endif
        drive_words(base, n, has_last, gap_mode, 0, acc);
        k = 0;
        while (busy && k < 2*n + 20) begin
            k++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        check_val({tag, " accepted"},    64'(acc), 64'(acc_exp));
        check_val({tag, " busy_cycles"}, 64'(k), 64'(exp_busy));
        check_val({tag, " n_writes"},    64'(wq.size() - wb), 64'(acc_exp));
        for (int j = 0; j < acc_exp && wb + j < wq.size(); j++) begin
            ea = base + AW'(j);
            check_val({tag, " wr_addr"}, 64'(wq[wb+j].addr), 64'(ea));
            check_val({tag, " wr_data"}, 64'(wq[wb+j].data), 64'(words[j]));
            if (gap_mode == 0)
                check_val({tag, " wr_cycle"}, 64'(wq[wb+j].cyc - wq[wb].cyc), 64'(j));
        end
        check_val({tag, " word_count"}, 64'(word_count), 64'(acc_exp));
        check_val({tag, " checksum"},   64'(checksum), 64'(sum));
        check_val({tag, " done"},       64'(done), 64'(!exp_err));
        check_val({tag, " error"},      64'(error), 64'(exp_err));
        check_val({tag, " cpu_reset"},  64'(cpu_reset), 64'(exp_err));
        check_val({tag, " busy"},       64'(busy), 64'(0));
        check_val({tag, " src_ready"},  64'(src_ready), 64'(0));
        check_val({tag, " mem_enable"}, 64'(mem_enable), 64'(0));
        check_val({tag, " n_reads"},    64'(rq.size() - rb), 64'(exp_reads));
        for (int j = 0; j < exp_reads && rb + j < rq.size(); j++) begin
            ea = base + AW'(j);
            check_val({tag, " rd_addr"}, 64'(rq[rb+j]), 64'(ea));
        end
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int j = 0; j < n; j++) words.push_back($urandom);
    endtask

    initial begin
        int            acc;
        int            wb;
        int            n;
        bit            has_last;
        logic [AW-1:0] base;

        reset = 1'b1; start = 1'b0; base_addr = '0;
        src_valid = 1'b0; src_data = '0; src_last = 1'b0; fault_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst cpu_reset",  64'(cpu_reset), 64'(1));
        check_val("rst mem_enable", 64'(mem_enable), 64'(0));
        check_val("rst mem_rw",     64'(mem_read_write), 64'(1));
        check_val("rst mem_addr",   64'(mem_address), 64'(0));
        check_val("rst src_ready",  64'(src_ready), 64'(0));
        check_val("rst busy",       64'(busy), 64'(0));
        check_val("rst done",       64'(done), 64'(0));
        check_val("rst error",      64'(error), 64'(0));
        check_val("rst word_count", 64'(word_count), 64'(0));
        check_val("rst checksum",   64'(checksum), 64'(0));

        // back-to-back full load; last word lands exactly on DEPTH
        fill_words(8);
        words[0] = 32'h0610_0028;
        words[1] = 32'h0608_0058;
        do_load("b2b", 16'h0000, 8, 1'b1, 0);

        // same stream, valid on alternate cycles
        do_load("gaps", 16'h0000, 8, 1'b1, 1);

        // overflow without src_last, then a clean short load
        fill_words(DEPTH + 2);
        do_load("ovf", AW'($urandom), DEPTH + 2, 1'b0, 0);
        fill_words(3);
        do_load("after_ovf", 16'h0040, 3, 1'b1, 0);

        // address wrap
        fill_words(3);
        do_load("wrap", 16'hFFFE, 3, 1'b1, 2);

        // reset after two accepted words aborts the load
        fill_words(5);
        base = 16'h1000 + AW'($urandom_range(0, 255));
        wb = wq.size();
        drive_words(base, 5, 1'b1, 0, 2, acc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_val("abort accepted",   64'(acc), 64'(2));
        check_val("abort n_writes",   64'(wq.size() - wb), 64'(2));
        check_val("abort busy",       64'(busy), 64'(0));
        check_val("abort cpu_reset",  64'(cpu_reset), 64'(1));
        check_val("abort done",       64'(done), 64'(0));
        check_val("abort word_count", 64'(word_count), 64'(0));
        check_val("abort ram0",       64'(ram[base]), 64'(words[0]));
        check_val("abort ram1",       64'(ram[AW'(base + 16'd1)]), 64'(words[1]));

        // corrupted readback of address 3 (only observable with readback verify)
        fault_en = 1'b1;
        fill_words(5);
        do_load("fault", 16'h0000, 5, 1'b1, 0);
        fault_en = 1'b0;
        do_load("nofault", 16'h0000, 5, 1'b1, 0);

        // randomised loads
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(1, DEPTH + 3);
            has_last = ($urandom_range(0, 3) != 0);
            if (!has_last && n < DEPTH) has_last = 1'b1;
            fill_words(n);
            do_load("rand", AW'($urandom), n, has_last, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected $finish before the time limit");
        $fatal(1, "watchdog");
    end

endmodule
